// File: rtl/button_debouncer.sv
// Button debouncer: two-flop synchroniser followed by a four-state debounce FSM.
// The debounced level flips only after the synchronised input has disagreed with
// it on STABLE_CYCLES+1 consecutive edges (entry into WAIT plus STABLE_CYCLES
// counted cycles). One-cycle pulses mark each accepted edge, and a wrapping
// counter tracks accepted presses.
//
// Ports:
//   clk         - rising-edge clock
//   rst         - synchronous, active-high reset
//   btn_in      - raw asynchronous button input (1 = pressed)
//   btn_level   - debounced level (registered)
//   rise_pulse  - one-cycle pulse on each accepted 0->1 flip
//   fall_pulse  - one-cycle pulse on each accepted 1->0 flip
//   press_count - number of accepted presses, wraps modulo 2^PCNT_W
module button_debouncer #(
  parameter int unsigned STABLE_CYCLES = 1000,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned PCNT_W        = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_in,
  output logic              btn_level,
  output logic              rise_pulse,
  output logic              fall_pulse,
  output logic [PCNT_W-1:0] press_count
);

  // Reject parameter sets where the terminal count cannot be represented.
  if (STABLE_CYCLES < 1 || 64'(STABLE_CYCLES) > ((64'(1) << CNT_W) - 64'(1))) begin : g_param_check
    $error("button_debouncer: STABLE_CYCLES must be in 1 .. 2^CNT_W-1");
  end

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    WAIT_HI = 2'd1,
    IDLE_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_e;

  logic              sync1_q, sync2_q;
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              level_q, level_d;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;
  logic [PCNT_W-1:0] pcnt_q, pcnt_d;

  // Next-state and output logic; cnt defaults to 0 so only WAIT can advance it.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    pcnt_d  = pcnt_q;
    unique case (state_q)
      IDLE_LO: begin
        if (sync2_q != level_q) state_d = WAIT_HI;
      end
      IDLE_HI: begin
        if (sync2_q != level_q) state_d = WAIT_LO;
      end
      WAIT_HI: begin
        if (sync2_q == level_q) begin
          state_d = IDLE_LO;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_HI;
          level_d = 1'b1;
          rise_d  = 1'b1;
          pcnt_d  = pcnt_q + PCNT_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_LO: begin
        if (sync2_q == level_q) begin
          state_d = IDLE_HI;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_LO;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE_LO;
    endcase
  end

  // State register, synchroniser and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= IDLE_LO;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      pcnt_q  <= '0;
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      pcnt_q  <= pcnt_d;
    end
  end

  assign btn_level   = level_q;
  assign rise_pulse  = rise_q;
  assign fall_pulse  = fall_q;
  assign press_count = pcnt_q;

endmodule
